// File: rtl/cpu16_pkg.sv
// cpu16_pkg: shared types and constants for the cpu16 core
//   DataWidthDef  default instruction word / PC width
//   fetch_state_t fetch stage FSM states
package cpu16_pkg;
  localparam int DataWidthDef = 16;
  typedef enum logic [1:0] {RUN, DRAIN, HALTED} fetch_state_t;
endpackage

// File: rtl/fetch_fifo.sv
// fetch_fifo: synchronous FIFO with clear and occupancy count, registered head
//   clk, rstN         clock, asynchronous active-low reset
//   i_push, i_data    write strobe and data
//   i_pop             read strobe (caller never pops when empty)
//   i_clear           empties the FIFO, overrides push/pop
//   o_head, o_count   head entry and occupancy
module fetch_fifo #(
  parameter int Width = 16,
  parameter int Depth = 2,
  localparam int CntWidth = $clog2(Depth + 1),
  localparam int PtrWidth = (Depth > 1) ? $clog2(Depth) : 1
) (
  input  logic                clk,
  input  logic                rstN,
  input  logic                i_push,
  input  logic [Width-1:0]    i_data,
  input  logic                i_pop,
  input  logic                i_clear,
  output logic [Width-1:0]    o_head,
  output logic [CntWidth-1:0] o_count
);
  logic [Width-1:0] r_mem [Depth];
  logic [PtrWidth-1:0] r_rd, r_wr;
  logic [CntWidth-1:0] r_cnt;
  function automatic logic [PtrWidth-1:0] inc(input logic [PtrWidth-1:0] p);
    return (p == PtrWidth'(Depth - 1)) ? '0 : p + 1'b1;
  endfunction
  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      r_mem <= '{default: '0};
      r_rd <= '0;
      r_wr <= '0;
      r_cnt <= '0;
    end else if (i_clear) begin
      r_rd <= '0;
      r_wr <= '0;
      r_cnt <= '0;
    end else begin
      if (i_push) r_mem[r_wr] <= i_data;
      if (i_push) r_wr <= inc(r_wr);
      if (i_pop) r_rd <= inc(r_rd);
      r_cnt <= r_cnt + CntWidth'(i_push) - CntWidth'(i_pop);
    end
  end
  assign o_head = r_mem[r_rd];
  assign o_count = r_cnt;
endmodule

// File: rtl/instruction_fetch.sv
// instruction_fetch: cpu16 fetch stage, issues PC reads and buffers returned words
//   clk, rstN                    clock, asynchronous active-low reset
//   programCounter, countEnable  PC from / increment strobe to the register file
//   memReq*, memRsp*             instruction memory request/response port
//   flush                        jump redirect, discards fetched and in-flight words
//   haltReq, haltAck             stop-fetch request and halted indication
//   instrValid/Ready, instr, instrPc  buffered instruction stream to decode
//   FETCH_PC_TAG_EN              when defined, each word carries its fetch PC on instrPc
module instruction_fetch
  import cpu16_pkg::*;
#(
  parameter int DataWidth  = DataWidthDef,
  parameter int QueueDepth = 2,
  parameter int CntWidth   = $clog2(QueueDepth + 1)
) (
  input  logic                 clk,
  input  logic                 rstN,
  input  logic [DataWidth-1:0] programCounter,
  output logic                 countEnable,
  output logic                 memReqValid,
  input  logic                 memReqReady,
  output logic [DataWidth-1:0] memReqAddr,
  input  logic                 memRspValid,
  input  logic [DataWidth-1:0] memRspData,
  input  logic                 flush,
  input  logic                 haltReq,
  output logic                 haltAck,
  output logic                 instrValid,
  input  logic                 instrReady,
  output logic [DataWidth-1:0] instr,
  output logic [DataWidth-1:0] instrPc
);
  localparam int SumWidth = CntWidth + 2;
`ifdef FETCH_PC_TAG_EN
  localparam int BufWidth = 2 * DataWidth;
`else
  localparam int BufWidth = DataWidth;
`endif
  fetch_state_t r_state, w_state_nxt;
  logic [CntWidth-1:0] r_live, r_drop, w_live_nxt, w_drop_nxt, w_count;
  logic [SumWidth-1:0] w_used;
  logic w_issue, w_rsp, w_keep, w_push, w_pop;
  logic [BufWidth-1:0] w_buf_in, w_buf_head;
  // credits: every accepted request reserves a buffer slot until its word is popped
  assign w_used = SumWidth'(r_live) + SumWidth'(r_drop) + SumWidth'(w_count);
  // rstN gate keeps the request low while reset is held
  assign w_issue = rstN && r_state == RUN && !flush && w_used < SumWidth'(QueueDepth);
  assign memReqValid = w_issue;
  assign memReqAddr = programCounter;
  assign countEnable = w_issue && memReqReady;
  assign w_rsp = memRspValid && (r_live != '0 || r_drop != '0);
  assign w_keep = w_rsp && r_drop == '0;
  assign w_push = w_keep && !flush;
  assign instrValid = w_count != '0;
  assign w_pop = instrValid && instrReady && !flush;
  assign w_live_nxt = flush ? '0 : r_live + CntWidth'(countEnable) - CntWidth'(w_keep);
  // on flush all live requests become drops, less the one answered this cycle
  assign w_drop_nxt = flush ? r_drop + r_live - CntWidth'(w_rsp) : r_drop - CntWidth'(w_rsp && !w_keep);
  assign haltAck = r_state == HALTED;
  always_comb begin
    w_state_nxt = r_state;
    if (r_state == RUN) w_state_nxt = haltReq ? DRAIN : RUN;
    else if (!haltReq) w_state_nxt = RUN;
    else if (w_live_nxt == '0 && w_drop_nxt == '0) w_state_nxt = HALTED;
  end
  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      r_state <= RUN;
      r_live <= '0;
      r_drop <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_live <= w_live_nxt;
      r_drop <= w_drop_nxt;
    end
  end
`ifdef FETCH_PC_TAG_EN
  logic [DataWidth-1:0] w_pend_pc;
  logic [CntWidth-1:0] w_pend_count;
  // holds the addresses of live requests only; dropped ones never need a tag
  fetch_fifo #(.Width(DataWidth), .Depth(QueueDepth)) u_pend (
    .clk(clk), .rstN(rstN), .i_push(countEnable), .i_data(programCounter),
    .i_pop(w_keep), .i_clear(flush), .o_head(w_pend_pc), .o_count(w_pend_count)
  );
  assign w_buf_in = {w_pend_pc, memRspData};
  assign instrPc = w_buf_head[BufWidth-1:DataWidth];
  a_pend_live: assert property (@(posedge clk) disable iff (!rstN) w_pend_count == r_live);
`else
  assign w_buf_in = memRspData;
  assign instrPc = '0;
`endif
  fetch_fifo #(.Width(BufWidth), .Depth(QueueDepth)) u_buf (
    .clk(clk), .rstN(rstN), .i_push(w_push), .i_data(w_buf_in),
    .i_pop(w_pop), .i_clear(flush), .o_head(w_buf_head), .o_count(w_count)
  );
  assign instr = w_buf_head[DataWidth-1:0];
  a_rsp_protocol: assert property (@(posedge clk) disable iff (!rstN) memRspValid |-> (r_live != '0 || r_drop != '0));
endmodule

// File: tb/tb_instruction_fetch.sv
// tb_instruction_fetch: randomized scoreboard bench for instruction_fetch
module tb_instruction_fetch;
  localparam int DW = 16;
  localparam int QD = 2;
`ifdef FETCH_PC_TAG_EN
  localparam bit PC_TAG = 1'b1;
`else
  localparam bit PC_TAG = 1'b0;
`endif
  typedef struct {logic [DW-1:0] addr; int due; int gen;} req_t;
  typedef struct {logic [DW-1:0] addr; logic [DW-1:0] data;} ins_t;
  logic clk = 1'b0, rstN = 1'b1;
  logic [DW-1:0] programCounter = '0, memReqAddr, memRspData = '0, instr, instrPc;
  logic countEnable, memReqValid, memRspValid = 1'b0, haltAck, instrValid;
  logic memReqReady = 1'b0, flush = 1'b0, haltReq = 1'b0, instrReady = 1'b0;
  req_t mem_q[$];
  ins_t exp_q[$];
  req_t mon_r;
  ins_t mon_e;
  logic mon_ev;
  logic [DW-1:0] pc = '0, flush_target = '0;
  int cyc = 0, gen = 0, n_cmp = 0, n_bad = 0, rsp_prob = 100, lat_extra = 0;
  bit nonrun = 1'b0, exp_ack = 1'b0;
  instruction_fetch dut (
    .clk(clk), .rstN(rstN), .programCounter(programCounter), .countEnable(countEnable),
    .memReqValid(memReqValid), .memReqReady(memReqReady), .memReqAddr(memReqAddr),
    .memRspValid(memRspValid), .memRspData(memRspData), .flush(flush),
    .haltReq(haltReq), .haltAck(haltAck), .instrValid(instrValid), .instrReady(instrReady),
    .instr(instr), .instrPc(instrPc)
  );
  always #5 clk = ~clk;
  function automatic logic [DW-1:0] mem_data(input logic [DW-1:0] a);
    return {a[7:0], a[15:8]} ^ 16'hC3A5;
  endfunction
  task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #2;
  endtask
  // memory and register file: in-order responses, PC driven from the bench's PC register
  always @(posedge clk) begin
    cyc++;
    #1;
    programCounter = pc;
    if (rstN && mem_q.size() != 0 && mem_q[0].due <= cyc && int'($urandom_range(0, 99)) < rsp_prob) begin
      memRspValid = 1'b1;
      memRspData = mem_data(mem_q[0].addr);
    end else begin
      memRspValid = 1'b0;
      memRspData = DW'($urandom);
    end
  end
  // monitor: compares the DUT against the reference queues, then applies this cycle's edge
  always @(negedge clk) begin
    if (rstN) begin
      mon_ev = !nonrun && !flush && (mem_q.size() + exp_q.size() < QD);
      check("memReqValid", DW'(memReqValid), DW'(mon_ev));
      check("countEnable", DW'(countEnable), DW'(mon_ev && memReqReady));
      if (memReqValid) check("memReqAddr", memReqAddr, pc);
      check("haltAck", DW'(haltAck), DW'(exp_ack));
      check("instrValid", DW'(instrValid), DW'(exp_q.size() != 0));
      if (instrValid && instrReady && !flush && exp_q.size() != 0) begin
        mon_e = exp_q.pop_front();
        check("instr", instr, mon_e.data);
        check("instrPc", instrPc, PC_TAG ? mon_e.addr : '0);
      end
      if (memRspValid && mem_q.size() != 0) begin
        mon_r = mem_q.pop_front();
        if (!flush && mon_r.gen == gen) exp_q.push_back('{mon_r.addr, mem_data(mon_r.addr)});
      end
      if (countEnable) begin
        mem_q.push_back('{pc, cyc + 1 + int'($urandom_range(0, lat_extra)), gen});
        pc = pc + 1'b1;
      end
      if (flush) begin
        gen++;
        exp_q.delete();
        pc = flush_target;
      end
      exp_ack = haltReq && nonrun && mem_q.size() == 0;
      nonrun = haltReq;
    end
  end
  task automatic check_reset_outputs(input string tag);
    check({tag, "_memReqValid"}, DW'(memReqValid), '0);
    check({tag, "_countEnable"}, DW'(countEnable), '0);
    check({tag, "_instrValid"}, DW'(instrValid), '0);
    check({tag, "_instr"}, instr, '0);
    check({tag, "_instrPc"}, instrPc, '0);
    check({tag, "_haltAck"}, DW'(haltAck), '0);
  endtask
  task automatic wait_inflight2(input string tag);
    for (int i = 0; i < 30 && mem_q.size() < 2; i++) step();
    check(tag, DW'(mem_q.size()), DW'(2));
  endtask
  task automatic wait_valid(input string tag);
    for (int i = 0; i < 30 && !instrValid; i++) @(negedge clk);
    check(tag, DW'(instrValid), DW'(1));
  endtask
  initial begin
    pc = 16'h0010;
    memReqReady = 1'b1;
    instrReady = 1'b1;
    #3 rstN = 1'b0;
    repeat (3) step();
    check_reset_outputs("reset");
    rstN = 1'b1;
    @(negedge clk);
    check("lat_c1_req", DW'(memReqValid), DW'(1));
    check("lat_c1_valid", DW'(instrValid), '0);
    @(negedge clk);
    check("lat_c2_valid", DW'(instrValid), '0);
    @(negedge clk);
    check("lat_c3_valid", DW'(instrValid), DW'(1));
    check("lat_c3_instr", instr, mem_data(16'h0010));
    repeat (8) step();
    instrReady = 1'b0;
    repeat (6) step();
    check("stall_req_low", DW'(memReqValid), '0);
    check("stall_head_valid", DW'(instrValid), DW'(1));
    instrReady = 1'b1;
    repeat (4) step();
    rsp_prob = 0;
    wait_inflight2("flush_setup");
    instrReady = 1'b0;
    rsp_prob = 100;
    step();
    rsp_prob = 0;
    step();
    flush_target = 16'h0200;
    flush = 1'b1;
    step();
    flush = 1'b0;
    rsp_prob = 100;
    instrReady = 1'b1;
    @(negedge clk);
    check("flush_cleared", DW'(instrValid), '0);
    wait_valid("flush_wait");
    check("flush_first_instr", instr, mem_data(16'h0200));
    check("flush_first_pc", instrPc, PC_TAG ? 16'h0200 : '0);
    step();
    rsp_prob = 0;
    wait_inflight2("halt_setup");
    haltReq = 1'b1;
    step();
    rsp_prob = 100;
    for (int i = 0; i < 30 && !haltAck; i++) @(negedge clk);
    check("halt_ack", DW'(haltAck), DW'(1));
    repeat (5) step();
    check("halted_no_req", DW'(memReqValid), '0);
    haltReq = 1'b0;
    step();
    step();
    check("resume_req", DW'(memReqValid), DW'(1));
    repeat (4) step();
    flush_target = 16'hFFFF;
    flush = 1'b1;
    step();
    flush = 1'b0;
    wait_valid("wrap_wait");
    check("wrap_first", instr, mem_data(16'hFFFF));
    @(negedge clk);
    check("wrap_second", instr, mem_data(16'h0000));
    step();
    rsp_prob = 0;
    wait_inflight2("reset_setup");
    rstN = 1'b0;
    #1;
    check_reset_outputs("midreset");
    mem_q.delete();
    exp_q.delete();
    nonrun = 1'b0;
    exp_ack = 1'b0;
    pc = 16'h0040;
    rsp_prob = 100;
    repeat (2) step();
    rstN = 1'b1;
    repeat (8) step();
    lat_extra = 3;
    rsp_prob = 70;
    for (int i = 0; i < 800; i++) begin
      memReqReady = $urandom_range(0, 3) != 0;
      instrReady = $urandom_range(0, 3) != 0;
      flush = $urandom_range(0, 29) == 0;
      flush_target = DW'($urandom);
      if ($urandom_range(0, 39) == 0) haltReq = !haltReq;
      step();
    end
    flush = 1'b0;
    haltReq = 1'b0;
    repeat (10) step();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
